// File: rtl/rs7_5_gf8_decoder.sv
// Serial RS(7,5) decoder over GF(8), single-symbol correction.
// Define RS7_5_ERR_CNT_EN to build the corrected-codeword counter.
module rs7_5_gf8_decoder #(
  parameter int EMIT_PARITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sym,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_sym,
  output logic        out_last,
  output logic        out_corrected,
  output logic        out_uncorr,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {COLLECT, SOLVE, EMIT} state_t;

  localparam logic [2:0] LAST = (EMIT_PARITY != 0) ? 3'd6 : 3'd4;

  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      if (b[i]) p = p ^ ({2'b00, a} << i);
    if (p[4]) p = p ^ 5'b10110;
    if (p[3]) p = p ^ 5'b01011;
    return p[2:0];
  endfunction

  function automatic logic [2:0] gf_inv(input logic [2:0] a);
    logic [2:0] r;
    unique case (a)
      3'd1:    r = 3'd1;
      3'd2:    r = 3'd5;
      3'd3:    r = 3'd6;
      3'd4:    r = 3'd7;
      3'd5:    r = 3'd2;
      3'd6:    r = 3'd3;
      3'd7:    r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  state_t     state, state_nx;
  logic [2:0] sym_buf [7];
  logic [2:0] s1, s2, count, idx, p, loc, mag;
  logic       corrected, uncorr;
  logic       acc, out_hs, fix, bad;

  assign acc    = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign fix    = (s1 != 3'd0) && (s2 != 3'd0);
  assign bad    = (s1 == 3'd0) ^ (s2 == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (acc && count == 3'd6) state_nx = SOLVE;
      SOLVE:   state_nx = EMIT;
      EMIT:    if (out_hs && out_last) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_comb begin
    in_ready      = (state == COLLECT);
    out_valid     = (state == EMIT);
    out_last      = (state == EMIT) && (idx == LAST);
    out_corrected = corrected;
    out_uncorr    = uncorr;
    out_sym       = '0;
    if (state == EMIT)
      out_sym = sym_buf[idx] ^ ((corrected && p == loc) ? mag : 3'd0);
  end

  always_ff @(posedge clk) begin
    if (acc) sym_buf[count] <= in_sym;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0; s2 <= '0; count <= '0; idx <= '0;
      p <= '0; loc <= '0; mag <= '0;
      corrected <= 1'b0; uncorr <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (acc) begin
          s1 <= gf_mul(s1, 3'd2) ^ in_sym;
          s2 <= gf_mul(s2, 3'd4) ^ in_sym;
          if (count != 3'd6) count <= count + 3'd1;
        end
        SOLVE: begin
          loc       <= gf_mul(s2, gf_inv(s1));
          mag       <= gf_mul(gf_mul(s1, s1), gf_inv(s2));
          corrected <= fix;
          uncorr    <= bad;
          idx       <= '0;
          p         <= 3'd5;
        end
        EMIT: if (out_hs) begin
          // p tracks a^(6-idx), the locator value of the symbol on the output
          p   <= gf_mul(p, 3'd5);
          idx <= idx + 3'd1;
          if (out_last) begin
            s1 <= '0; s2 <= '0; count <= '0; idx <= '0; p <= '0;
            corrected <= 1'b0; uncorr <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RS7_5_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (state == SOLVE && fix && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rs7_5_gf8_decoder.sv
// Bench for rs7_5_gf8_decoder: table vectors, scoreboard queues,
// backpressure, EMIT_PARITY=0 and mid-codeword reset sequences.
module tb_rs7_5_gf8_decoder;

  typedef logic [2:0] sym7_t [7];
  typedef struct {
    sym7_t in;
    sym7_t exp;
    bit    corr;
    bit    unc;
  } vec_t;
  typedef struct packed {
    logic [2:0] sym;
    logic       last;
    logic       corr;
    logic       unc;
  } ob_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic out_last_a, out_corr_a, out_unc_a;
  logic [2:0] in_sym_a, out_sym_a;
  logic [15:0] err_cnt_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic out_last_b, out_corr_b, out_unc_b;
  logic [2:0] in_sym_b, out_sym_b;
  logic [15:0] err_cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_fix = 0;
  ob_t qa[$];
  ob_t qb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  rs7_5_gf8_decoder #(.EMIT_PARITY(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sym(in_sym_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sym(out_sym_a),
    .out_last(out_last_a), .out_corrected(out_corr_a),
    .out_uncorr(out_unc_a), .err_cnt(err_cnt_a)
  );

  rs7_5_gf8_decoder #(.EMIT_PARITY(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sym(in_sym_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sym(out_sym_b),
    .out_last(out_last_b), .out_corrected(out_corr_b),
    .out_uncorr(out_unc_b), .err_cnt(err_cnt_b)
  );

  function automatic sym7_t w(input int a, input int b, input int c,
                              input int d, input int e, input int f,
                              input int g);
    sym7_t r;
    r[0] = a[2:0]; r[1] = b[2:0]; r[2] = c[2:0]; r[3] = d[2:0];
    r[4] = e[2:0]; r[5] = f[2:0]; r[6] = g[2:0];
    return r;
  endfunction

  function automatic int cnt_exp(input int n);
`ifdef RS7_5_ERR_CNT_EN
    return n;
`else
    return n - n;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input bit sel, input sym7_t e, input bit corr, input bit unc);
    int n;
    ob_t o;
    n = sel ? 5 : 7;
    for (int i = 0; i < n; i++) begin
      o.sym  = e[i];
      o.last = (i == n - 1);
      o.corr = corr;
      o.unc  = unc;
      if (sel) qb.push_back(o);
      else     qa.push_back(o);
    end
  endtask

  task automatic send(input bit sel, input sym7_t s, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (sel) begin in_valid_b = 1'b1; in_sym_b = s[i]; end
      else     begin in_valid_a = 1'b1; in_sym_a = s[i]; end
      t = 0;
      while (!(sel ? in_ready_b : in_ready_a) && t < 100) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int t;
    t = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk(sel ? "drain_b" : "drain_a", sel ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    ob_t o, g;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_a && out_ready_a) begin
        g = '{sym: out_sym_a, last: out_last_a, corr: out_corr_a, unc: out_unc_a};
        if (qa.size() == 0) chk("unexpected_out_a", int'(g), -1);
        else begin
          o = qa.pop_front();
          chk("out_a{sym,last,corr,unc}", int'(g), int'(o));
        end
      end
      if (!rst && out_valid_b && out_ready_b) begin
        g = '{sym: out_sym_b, last: out_last_b, corr: out_corr_b, unc: out_unc_b};
        if (qb.size() == 0) chk("unexpected_out_b", int'(g), -1);
        else begin
          o = qb.pop_front();
          chk("out_b{sym,last,corr,unc}", int'(g), int'(o));
        end
      end
    end
  end

  initial begin
    logic [2:0] h_sym;
    logic h_corr, h_unc;
    tbl[0] = '{in: w(0,0,0,0,1,6,3), exp: w(0,0,0,0,1,6,3), corr: 0, unc: 0};
    tbl[1] = '{in: w(0,0,5,0,1,6,3), exp: w(0,0,0,0,1,6,3), corr: 1, unc: 0};
    tbl[2] = '{in: w(2,0,0,0,0,0,1), exp: w(2,0,0,0,0,0,1), corr: 0, unc: 1};
    tbl[3] = '{in: w(0,0,0,0,1,6,4), exp: w(0,0,0,0,1,6,3), corr: 1, unc: 0};
    tbl[4] = '{in: w(4,0,0,1,6,3,0), exp: w(0,0,0,1,6,3,0), corr: 1, unc: 0};
    tbl[5] = '{in: w(0,0,0,0,2,7,6), exp: w(0,0,0,0,2,7,6), corr: 0, unc: 0};

    rst = 1'b1;
    in_valid_a = 1'b0; in_sym_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_sym_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_out_sym", out_sym_a, 0);
    chk("rst_corrected", out_corr_a, 0);
    chk("rst_uncorr", out_unc_a, 0);
    chk("rst_err_cnt", err_cnt_a, 0);
    chk("rst_b_out_valid", out_valid_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      push_exp(0, tbl[v].exp, tbl[v].corr, tbl[v].unc);
      send(0, tbl[v].in, 7);
      chk($sformatf("v%0d_solve_gap", v), out_valid_a, 0);
      chk($sformatf("v%0d_solve_in_ready", v), in_ready_a, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_first_valid", v), out_valid_a, 1);
      if (tbl[v].corr) n_fix++;
      drain(0);
      chk($sformatf("v%0d_err_cnt", v), err_cnt_a, cnt_exp(n_fix));
      chk($sformatf("v%0d_back_ready", v), in_ready_a, 1);
    end

    // stall the third output symbol for three cycles
    push_exp(0, w(0,0,0,0,1,6,3), 1, 0);
    send(0, w(0,0,5,0,1,6,3), 7);
    n_fix++;
    repeat (3) begin @(posedge clk); #1; end
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_sym_a = 3'd7;
    h_sym = out_sym_a; h_corr = out_corr_a; h_unc = out_unc_a;
    chk("bp_third_sym", h_sym, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d{valid,sym,corr,unc,in_ready}", i),
          int'({out_valid_a, out_sym_a, out_corr_a, out_unc_a, in_ready_a}),
          int'({1'b1, h_sym, h_corr, h_unc, 1'b0}));
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    drain(0);
    chk("bp_err_cnt", err_cnt_a, cnt_exp(n_fix));

    push_exp(1, w(0,0,0,0,1,6,3), 1, 0);
    send(1, w(0,0,5,0,1,6,3), 7);
    drain(1);
    chk("b_next_ready", in_ready_b, 1);
    push_exp(1, w(0,0,0,0,1,6,3), 0, 0);
    send(1, w(0,0,0,0,1,6,3), 7);
    drain(1);
    chk("b_err_cnt", err_cnt_b, cnt_exp(1));

    send(0, w(0,0,5,0,1,6,3), 4);
    rst = 1'b1;
    #3;
    chk("mid_rst_valid_pre", out_valid_a, 0);
    @(posedge clk); #1;
    chk("mid_rst_valid_post", out_valid_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    rst = 1'b0;
    n_fix = 0;
    push_exp(0, w(0,0,0,0,1,6,3), 0, 0);
    send(0, w(0,0,0,0,1,6,3), 7);
    chk("post_rst_solve_gap", out_valid_a, 0);
    drain(0);
    chk("post_rst_err_cnt", err_cnt_a, cnt_exp(n_fix));
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_output", out_valid_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
